// File: rtl/lvds_tx_framer.sv
// lvds_tx_framer: pulls I/Q words from the TX FIFO and serialises them as framed dibits, inserting zero frames on underrun
module lvds_tx_framer #(
  parameter logic [1:0] SYNC_I     = 2'b10,
  parameter logic [1:0] SYNC_Q     = 2'b01,
  parameter int         UNDERRUN_W = 8
) (
  input  logic                  i_ddr_clk,
  input  logic                  i_rst,
  input  logic                  i_tx_enable,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_pull,
  input  logic [31:0]           i_fifo_data,
  output logic [1:0]            o_ddr_data,
  output logic                  o_busy,
  input  logic                  i_clear_underrun,
  output logic [UNDERRUN_W-1:0] o_underrun_cnt,
  output logic [1:0]            o_debug_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, TX = 2'd2} state_t;
  localparam logic [31:0] ZERO_FRAME = {SYNC_I, 14'd0, SYNC_Q, 14'd0};
  state_t                  state_q, state_d;
  logic [31:0]             shreg_q, shreg_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    pulled_q, pulled_d;
  logic                    en14_q, en14_d;
  logic [UNDERRUN_W-1:0]   urun_q, urun_d;
  logic [31:0]             framed;
  logic                    pull;
  logic                    inc;
  logic                    unused_hi;
  assign unused_hi = ^{i_fifo_data[31:29], i_fifo_data[15:13]};
  assign framed = {SYNC_I, i_fifo_data[28:16], 1'b0, SYNC_Q, i_fifo_data[12:0], 1'b0};
  // The only pull points are IDLE and the second-to-last dibit of a frame; gated so reset never pulls
  assign pull = !i_rst && i_tx_enable && !i_fifo_empty &&
                (state_q == IDLE || (state_q == TX && cnt_q == 4'd14));
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    pulled_d = pulled_q;
    en14_d   = en14_q;
    inc      = 1'b0;
    unique case (state_q)
      IDLE: begin
        shreg_d = '0;
        cnt_d   = '0;
        state_d = pull ? PRIME : IDLE;
      end
      PRIME: begin
        shreg_d = framed;
        cnt_d   = '0;
        state_d = TX;
      end
      TX: begin
        shreg_d = {shreg_q[29:0], 2'b00};
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd14) begin
          pulled_d = pull;
          en14_d   = i_tx_enable;
        end
        if (cnt_q == 4'd15) begin
          shreg_d = pulled_q ? framed : en14_q ? ZERO_FRAME : '0;
          inc     = !pulled_q && en14_q;
          state_d = (pulled_q || en14_q) ? TX : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    urun_d = i_clear_underrun ? '0 :
             (inc && urun_q != '1) ? urun_q + UNDERRUN_W'(1) : urun_q;
  end
  always_ff @(posedge i_ddr_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      pulled_q <= 1'b0;
      en14_q   <= 1'b0;
      urun_q   <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      pulled_q <= pulled_d;
      en14_q   <= en14_d;
      urun_q   <= urun_d;
    end
  end
  assign o_fifo_pull    = pull;
  assign o_ddr_data     = shreg_q[31:30];
  assign o_busy         = state_q != IDLE;
  assign o_underrun_cnt = urun_q;
  assign o_debug_state  = state_q;
endmodule

// File: tb/tb_lvds_tx_framer.sv
// tb_lvds_tx_framer: table vectors, directed corner sequences and a frame-level scoreboard for lvds_tx_framer
module tb_lvds_tx_framer;
  logic        clk = 1'b0;
  logic        rst, en, empty, clr;
  logic [31:0] data;
  logic        pull, busy;
  logic [1:0]  ddr, st;
  logic [7:0]  urun;
  int          vectors = 0;
  int          fails = 0;
  logic [31:0] fifo[$];
  localparam logic [31:0] ZERO = 32'h80004000;

  lvds_tx_framer dut (
    .i_ddr_clk(clk), .i_rst(rst), .i_tx_enable(en), .i_fifo_empty(empty),
    .o_fifo_pull(pull), .i_fifo_data(data), .o_ddr_data(ddr), .o_busy(busy),
    .i_clear_underrun(clr), .o_underrun_cnt(urun), .o_debug_state(st)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, empty;
    logic [31:0] data;
    logic        pull;
    logic [1:0]  ddr;
    logic        busy;
    logic [1:0]  st;
  } vec_t;
  vec_t tbl[18];

  function automatic logic [31:0] frame(input logic [31:0] w);
    return ZERO | (((w >> 16) & 32'h1FFF) << 17) | ((w & 32'h1FFF) << 1);
  endfunction

  function automatic logic [1:0] dibit(input logic [31:0] f, input int k);
    logic [31:0] s;
    s = f >> (30 - 2 * k);
    return s[1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic em, input logic [31:0] d, input logic c);
    @(negedge clk);
    rst = r; en = e; empty = em; data = d; clr = c;
    #2;
  endtask

  task automatic do_reset();
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    fifo.delete();
  endtask

  // Frame-level reference: stream starts two cycles after the first pull, then one frame per 16 cycles,
  // each frame being the next FIFO word if one was available at offset 14 of the previous frame, else zero.
  task automatic run_model(input int ncyc, input bit rnd, input int refill_pct, output int npull);
    int t0 = -1;
    int off, f, u = 0;
    logic [31:0] frames[$];
    bit zf[$];
    logic [31:0] nxt = 0, w;
    logic e_pull, blk, em;
    npull = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (refill_pct > 0 && $urandom_range(0, 99) < refill_pct && fifo.size() < 4) fifo.push_back($urandom);
      blk = rnd && ($urandom_range(0, 2) == 0);
      em = (fifo.size() == 0) || blk;
      step(0, 1, em, nxt, 0);
      off = (t0 >= 0 && c >= t0) ? (c - t0) % 16 : -1;
      f = (off >= 0) ? (c - t0) / 16 : 0;
      e_pull = !em && (t0 < 0 || off == 14);
      if (off == 0 && f >= 1 && zf[f]) u = (u == 255) ? 255 : u + 1;
      chk("m_pull", pull, e_pull);
      chk("m_ddr", ddr, off < 0 ? 2'b00 : dibit(frames[f], off));
      chk("m_busy", busy, t0 >= 0 && c >= t0 - 1);
      chk("m_urun", urun, u);
      nxt = 0;
      if (e_pull) begin
        w = fifo.pop_front();
        nxt = w;
        npull++;
        if (t0 < 0) t0 = c + 2;
        frames.push_back(frame(w));
        zf.push_back(0);
      end else if (off == 14) begin
        frames.push_back(ZERO);
        zf.push_back(1);
      end
    end
  endtask

  initial begin
    int np;
    logic [31:0] w1, fr;
    rst = 1; en = 0; empty = 1; data = 0; clr = 0;
    // reset state, no pull while reset even with enable and data present
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("rst_pull", pull, 0);
    chk("rst_ddr", ddr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", st, 0);
    chk("rst_urun", urun, 0);

    // test 1: single word, latency and bit order
    fr = 32'h82467578;
    tbl[0] = '{1, 0, 32'h0, 1, 2'b00, 0, 2'd0};
    tbl[1] = '{1, 1, 32'h01231ABC, 0, 2'b00, 1, 2'd1};
    for (int k = 0; k < 16; k++) tbl[k + 2] = '{1, 1, 32'h0, 0, dibit(fr, k), 1, 2'd2};
    for (int i = 0; i < 18; i++) begin
      step(0, tbl[i].en, tbl[i].empty, tbl[i].data, 0);
      chk($sformatf("t1_pull[%0d]", i), pull, tbl[i].pull);
      chk($sformatf("t1_ddr[%0d]", i), ddr, tbl[i].ddr);
      chk($sformatf("t1_busy[%0d]", i), busy, tbl[i].busy);
      chk($sformatf("t1_state[%0d]", i), st, tbl[i].st);
    end

    // test 2: three words back to back then a zero frame
    do_reset();
    fifo = '{32'h01231ABC, 32'hFFFF0000, 32'h1234ABCD};
    run_model(2 + 16 * 4, 0, 0, np);
    chk("t2_npull", np, 3);
    chk("t2_urun", urun, 1);

    // test 3: enable dropped mid-frame finishes the frame then idles
    do_reset();
    w1 = 32'hFFFF0000;
    step(0, 1, 0, 0, 0);
    chk("t3_pull0", pull, 1);
    step(0, 1, 0, w1, 0);
    chk("t3_prime_pull", pull, 0);
    chk("t3_prime_state", st, 1);
    for (int k = 0; k < 16; k++) begin
      step(0, k < 5, 0, 0, 0);
      chk($sformatf("t3_ddr[%0d]", k), ddr, dibit(32'hBFFE4000, k));
      chk($sformatf("t3_pull[%0d]", k), pull, 0);
    end
    step(0, 0, 0, 0, 0);
    chk("t3_idle_ddr", ddr, 0);
    chk("t3_idle_busy", busy, 0);
    chk("t3_idle_state", st, 0);
    chk("t3_idle_pull", pull, 0);

    // test 4: long underrun saturates, clear returns to zero
    do_reset();
    fifo = '{32'h0AAA5555};
    run_model(2 + 16 * 301, 0, 0, np);
    chk("t4_sat", urun, 255);
    step(0, 1, 1, 0, 1);
    step(0, 1, 1, 0, 0);
    chk("t4_clear", urun, 0);

    // test 5: reset at cnt 7 drops the frame; restart is clean
    do_reset();
    w1 = 32'h01231ABC;
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, w1, 0);
    for (int k = 0; k < 7; k++) begin
      step(0, 1, 1, 0, 0);
      chk($sformatf("t5_ddr[%0d]", k), ddr, dibit(frame(w1), k));
    end
    step(1, 1, 1, 0, 0);
    chk("t5_rst_pull", pull, 0);
    step(0, 0, 1, 0, 0);
    chk("t5_ddr", ddr, 0);
    chk("t5_state", st, 0);
    chk("t5_busy", busy, 0);
    fifo = '{32'h7654FEDC};
    run_model(2 + 16 * 2, 0, 0, np);
    chk("t5_npull", np, 1);

    // test 6: random empty toggling scoreboard
    do_reset();
    run_model(2 + 16 * 2000, 1, 6, np);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
